racer_race_engine: RTL and testbench

Parametrised game core for the LED racer. It accepts 1 to 8 raw player buttons and debounces each one. It tracks a position per player, runs an IDLE/RACE/WIN state machine and detects the winner. It hands position snapshots to the LED-strip serializer through a req/ack frame handshake. It replaces the fixed four-player game logic inside each board top and sits between the board pins and the WS2812 line driver.

---
 rtl/racer_race_engine.sv | 204 ++++++++++++++++++++
 tb/tb_racer_race_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/racer_race_engine.sv
// LED-racer game core: per-player debounce, IDLE/RACE/WIN control and a req/ack snapshot port.
// Define RACER_LAPS_EN to race LAPS laps instead of a single run to MAX_POS.
module racer_race_engine #(
  parameter  int PLAYERS          = 4,
  parameter  int MAX_POS          = 109,
  parameter  int DEBOUNCE_CLK_CNT = 65536,
  parameter  int WIN_HOLD_CLK_CNT = 50000000,
  parameter  int LAPS             = 3,
  localparam int PW               = $clog2(MAX_POS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PLAYERS-1:0]      btn_in,
  input  logic                    frame_ack,
  output logic                    frame_req,
  output logic [PLAYERS*PW-1:0]   pos_bus,
  output logic [PLAYERS*4-1:0]    lap_bus,
  output logic [1:0]              game_state,
  output logic                    winner_valid,
  output logic [2:0]              winner_id
);

  localparam int DW = $clog2(DEBOUNCE_CLK_CNT + 1);
  localparam int HW = $clog2(WIN_HOLD_CLK_CNT + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CLK_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD_CLK_CNT - 1);
  localparam logic [PW-1:0] POS_MAX   = PW'(MAX_POS);

  if (PLAYERS < 1 || PLAYERS > 8 || DEBOUNCE_CLK_CNT < 2 || WIN_HOLD_CLK_CNT < 1 ||
      LAPS < 1 || LAPS > 15) begin : g_param_check
    $error("racer_race_engine: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RACE = 2'd1,
    S_WIN  = 2'd2
  } state_e;

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (v == POS_MAX) ? v : v + 1'b1;
  endfunction

  logic [PLAYERS-1:0] sync1_q, sync2_q, stable_q, press_q;
  logic [DW-1:0]      deb_cnt_q [PLAYERS];

  state_e                  state_q, state_d;
  logic [PLAYERS*PW-1:0]   pos_q, pos_d, pos_snap_q;
  logic [2:0]              win_id_q, win_id_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [PLAYERS-1:0]      fin;
  logic                    frame_req_q, dirty_q, live_chg;
`ifdef RACER_LAPS_EN
  localparam logic [PW-1:0] POS_PRE  = PW'(MAX_POS - 1);
  localparam logic [3:0]    LAP_LAST = 4'(LAPS - 1);
  localparam logic [3:0]    LAP_FULL = 4'(LAPS);
  logic [PLAYERS*4-1:0]     lap_q, lap_d, lap_snap_q;
`endif

  // Press pulse is registered together with the stable level it came from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < PLAYERS; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < PLAYERS; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          stable_q[i]  <= sync2_q[i];
          press_q[i]   <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    win_id_d = win_id_q;
    hold_d   = hold_q;
    fin      = '0;
`ifdef RACER_LAPS_EN
    lap_d    = lap_q;
`endif
    unique case (state_q)
      S_IDLE: if (|press_q) state_d = S_RACE;
      S_RACE: begin
        for (int i = 0; i < PLAYERS; i++) begin
          if (press_q[i]) begin
`ifdef RACER_LAPS_EN
            if (pos_q[i*PW +: PW] == POS_MAX) begin
              pos_d[i*PW +: PW] = '0;
              lap_d[i*4 +: 4]   = lap_q[i*4 +: 4] + 4'd1;
            end else begin
              pos_d[i*PW +: PW] = sat_inc(pos_q[i*PW +: PW]);
              if (pos_q[i*PW +: PW] == POS_PRE && lap_q[i*4 +: 4] == LAP_LAST) begin
                lap_d[i*4 +: 4] = LAP_FULL;
                fin[i]          = 1'b1;
              end
            end
`else
            pos_d[i*PW +: PW] = sat_inc(pos_q[i*PW +: PW]);
            fin[i]            = (pos_d[i*PW +: PW] == POS_MAX);
`endif
          end
        end
        // Scan downwards so the lowest finishing index wins a tie.
        for (int i = PLAYERS - 1; i >= 0; i--) begin
          if (fin[i]) win_id_d = 3'(i);
        end
        if (|fin) begin
          state_d = S_WIN;
          hold_d  = '0;
        end
      end
      S_WIN: begin
        if (hold_q == HOLD_LAST) begin
          state_d  = S_IDLE;
          pos_d    = '0;
          win_id_d = '0;
          hold_d   = '0;
`ifdef RACER_LAPS_EN
          lap_d    = '0;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RACER_LAPS_EN
  assign live_chg = (pos_d != pos_q) || (lap_d != lap_q) || (state_d != state_q);
`else
  assign live_chg = (pos_d != pos_q) || (state_d != state_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      win_id_q <= '0;
      hold_q   <= '0;
`ifdef RACER_LAPS_EN
      lap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      win_id_q <= win_id_d;
      hold_q   <= hold_d;
`ifdef RACER_LAPS_EN
      lap_q    <= lap_d;
`endif
    end
  end

  // Snapshot takes the pre-edge live values; a change in the same cycle stays dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_req_q <= 1'b0;
      dirty_q     <= 1'b1;
      pos_snap_q  <= '0;
`ifdef RACER_LAPS_EN
      lap_snap_q  <= '0;
`endif
    end else if (frame_req_q) begin
      if (frame_ack) frame_req_q <= 1'b0;
      dirty_q <= dirty_q | live_chg;
    end else if (dirty_q) begin
      frame_req_q <= 1'b1;
      pos_snap_q  <= pos_q;
`ifdef RACER_LAPS_EN
      lap_snap_q  <= lap_q;
`endif
      dirty_q     <= live_chg;
    end else begin
      dirty_q <= live_chg;
    end
  end

  assign frame_req    = frame_req_q;
  assign pos_bus      = pos_snap_q;
`ifdef RACER_LAPS_EN
  assign lap_bus      = lap_snap_q;
`else
  assign lap_bus      = '0;
`endif
  assign game_state   = state_q;
  assign winner_valid = (state_q == S_WIN);
  assign winner_id    = win_id_q;

endmodule

// File: tb/tb_racer_race_engine.sv
// Bench for racer_race_engine: directed scenarios plus random buttons/acks against a behavioural model.
module tb_racer_race_engine;
  localparam int P    = 4;
  localparam int MAXP = 5;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int LAPS = 2;
  localparam int PW   = $clog2(MAXP + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [P-1:0]    btn = '0;
  logic            ack = 1'b0;
  logic            frame_req;
  logic [P*PW-1:0] pos_bus;
  logic [P*4-1:0]  lap_bus;
  logic [1:0]      game_state;
  logic            winner_valid;
  logic [2:0]      winner_id;

  int total = 0;
  int bad   = 0;

  racer_race_engine #(
    .PLAYERS(P), .MAX_POS(MAXP), .DEBOUNCE_CLK_CNT(DEB), .WIN_HOLD_CLK_CNT(HOLD), .LAPS(LAPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn), .frame_ack(ack), .frame_req(frame_req),
    .pos_bus(pos_bus), .lap_bus(lap_bus), .game_state(game_state),
    .winner_valid(winner_valid), .winner_id(winner_id)
  );

  always #5 clk = ~clk;

  // Behavioural model: game values as plain integers, button samples as a history queue.
  int m_pos[P], m_lap[P], s_pos[P], s_lap[P];
  int m_state, m_win, m_hold;
  bit m_dirty, m_freq;
  bit m_stable[P], m_press[P];
  bit hist[P][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int posf(int p);
    return int'(pos_bus[p*PW +: PW]);
  endfunction

  function automatic int lapf(int p);
    return int'(lap_bus[p*4 +: 4]);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      m_pos[p] = 0; m_lap[p] = 0; s_pos[p] = 0; s_lap[p] = 0;
      m_stable[p] = 0; m_press[p] = 0;
      hist[p].delete();
      repeat (DEB + 2) hist[p].push_back(1'b0);
    end
    m_state = 0; m_win = 0; m_hold = 0; m_dirty = 1; m_freq = 0;
  endtask

  task automatic model_edge();
    int  np[P];
    int  nl[P];
    int  ns, fin_lo;
    bit  changed, all_diff;
    np = m_pos; nl = m_lap; ns = m_state; fin_lo = -1;
    case (m_state)
      0: for (int p = 0; p < P; p++) if (m_press[p]) ns = 1;
      1: begin
        for (int p = 0; p < P; p++) begin
          if (m_press[p]) begin
`ifdef RACER_LAPS_EN
            if (np[p] == MAXP) begin
              np[p] = 0; nl[p]++;
            end else begin
              np[p]++;
              if (np[p] == MAXP && nl[p] + 1 == LAPS) begin
                nl[p] = LAPS;
                if (fin_lo < 0) fin_lo = p;
              end
            end
`else
            if (np[p] < MAXP) np[p]++;
            if (np[p] == MAXP && fin_lo < 0) fin_lo = p;
`endif
          end
        end
        if (fin_lo >= 0) begin ns = 2; m_win = fin_lo; m_hold = 0; end
      end
      default: begin
        m_hold++;
        if (m_hold == HOLD) begin
          ns = 0; m_win = 0;
          for (int p = 0; p < P; p++) begin np[p] = 0; nl[p] = 0; end
        end
      end
    endcase
    changed = (ns != m_state);
    for (int p = 0; p < P; p++) if (np[p] != m_pos[p] || nl[p] != m_lap[p]) changed = 1;
    if (m_freq) begin
      if (ack) m_freq = 0;
      m_dirty = m_dirty | changed;
    end else if (m_dirty) begin
      s_pos = m_pos; s_lap = m_lap; m_freq = 1; m_dirty = changed;
    end else begin
      m_dirty = changed;
    end
    m_pos = np; m_lap = nl; m_state = ns;
    // A level is accepted once the last DEB synchronised samples all disagree with it.
    for (int p = 0; p < P; p++) begin
      hist[p].push_back(btn[p]);
      void'(hist[p].pop_front());
      all_diff = 1;
      for (int j = 0; j < DEB; j++) if (hist[p][j] == m_stable[p]) all_diff = 0;
      m_press[p] = 0;
      if (all_diff) begin
        m_stable[p] = ~m_stable[p];
        m_press[p]  = m_stable[p];
      end
    end
  endtask

  task automatic compare_all();
    logic [P*PW-1:0] ep;
    logic [P*4-1:0]  el;
    for (int p = 0; p < P; p++) begin
      ep[p*PW +: PW] = PW'(s_pos[p]);
      el[p*4 +: 4]   = 4'(s_lap[p]);
    end
    check("frame_req", 32'(frame_req), 32'(m_freq));
    check("pos_bus", 32'(pos_bus), 32'(ep));
    check("lap_bus", 32'(lap_bus), 32'(el));
    check("game_state", 32'(game_state), 32'(m_state));
    check("winner_valid", 32'(winner_valid), 32'(m_state == 2));
    check("winner_id", 32'(winner_id), 32'(m_win));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press_mask(input logic [P-1:0] mask);
    btn = btn | mask;
    repeat (6) tick();
    btn = btn & ~mask;
    repeat (6) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_frame_req", 32'(frame_req), 32'd0);
    check("rst_pos_bus", 32'(pos_bus), 32'd0);
    check("rst_state", 32'(game_state), 32'd0);
    compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("init_frame_req", 32'(frame_req), 32'd0);
    check("init_winner_valid", 32'(winner_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_frame_req", 32'(frame_req), 32'd1);
    check("first_pos_bus", 32'(pos_bus), 32'd0);
    tick();
    check("first_frame_drop", 32'(frame_req), 32'd0);
    repeat (3) tick();
    check("no_extra_frame", 32'(frame_req), 32'd0);

    // Short glitch is rejected, a long hold starts the race without moving anyone.
    btn[1] = 1'b1;
    repeat (3) tick();
    btn[1] = 1'b0;
    repeat (8) tick();
    check("glitch_idle", 32'(game_state), 32'd0);
    press_mask(4'b0010);
    check("race_started", 32'(game_state), 32'd1);
    check("race_pos_zero", 32'(pos_bus), 32'd0);

`ifndef RACER_LAPS_EN
    repeat (5) press_mask(4'b0100);
    check("p2_pos", 32'(posf(2)), 32'd5);
    check("p2_state", 32'(game_state), 32'd2);
    check("p2_winner", 32'(winner_id), 32'd2);
    check("p2_valid", 32'(winner_valid), 32'd1);
    repeat (12) tick();
    check("hold_idle", 32'(game_state), 32'd0);
    check("hold_pos_clear", 32'(pos_bus), 32'd0);

    press_mask(4'b0001);
    repeat (4) press_mask(4'b0010);
    repeat (4) press_mask(4'b1000);
    check("tie_pre_p3", 32'(posf(3)), 32'd4);
    press_mask(4'b1010);
    check("tie_state", 32'(game_state), 32'd2);
    check("tie_winner", 32'(winner_id), 32'd1);
    check("tie_p1", 32'(posf(1)), 32'd5);
    check("tie_p3", 32'(posf(3)), 32'd5);
    repeat (12) tick();
`else
    for (int n = 1; n <= 11; n++) begin
      press_mask(4'b0001);
      if (n == 5) check("lap_p5_pos", 32'(posf(0)), 32'd5);
      if (n == 5) check("lap_p5_state", 32'(game_state), 32'd1);
      if (n == 6) check("lap_p6_pos", 32'(posf(0)), 32'd0);
      if (n == 6) check("lap_p6_lap", 32'(lapf(0)), 32'd1);
    end
    check("lap_win_state", 32'(game_state), 32'd2);
    check("lap_win_pos", 32'(posf(0)), 32'd5);
    check("lap_win_lap", 32'(lapf(0)), 32'd2);
    check("lap_win_id", 32'(winner_id), 32'd0);
`endif
    do_reset();
    tick();
    check("clean_idle", 32'(game_state), 32'd0);

    // Frames are coalesced while the serializer stalls.
    press_mask(4'b0001);
    ack = 1'b0;
    repeat (3) press_mask(4'b0001);
    check("stall_req", 32'(frame_req), 32'd1);
    check("stall_frozen", 32'(posf(0)), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_drop", 32'(frame_req), 32'd0);
    tick();
    check("coalesced_req", 32'(frame_req), 32'd1);
    check("coalesced_pos", 32'(posf(0)), 32'd3);
    repeat (3) tick();
    check("single_frame", 32'(frame_req), 32'd1);

    do_reset();
    check("midrace_state", 32'(game_state), 32'd0);
    tick();
    check("post_rst_req", 32'(frame_req), 32'd1);

    for (int k = 0; k < 4000; k++) begin
      for (int p = 0; p < P; p++) if ($urandom_range(0, 5) == 0) btn[p] = ~btn[p];
      ack = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
